// File: rtl/matrix_operand_loader_if.sv
// Host byte stream plus presented-operand bus between the operand loader, its host and the matrix core.
interface matrix_operand_loader_if #(
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic             s_last;
    logic             cfg_relu;
    logic [7:0]       matrixA_11, matrixA_12, matrixA_21, matrixA_22;
    logic [7:0]       matrixB_11, matrixB_12, matrixB_21, matrixB_22;
    logic             ReLU;
    logic             op_valid;
    logic             op_ack;
    logic             frame_err;
    logic [CNT_W-1:0] frame_count;

    modport slave (
        input  s_valid, s_data, s_last, cfg_relu, op_ack,
        output s_ready, matrixA_11, matrixA_12, matrixA_21, matrixA_22,
               matrixB_11, matrixB_12, matrixB_21, matrixB_22,
               ReLU, op_valid, frame_err, frame_count
    );

    modport master (
        output s_valid, s_data, s_last, cfg_relu, op_ack,
        input  s_ready, matrixA_11, matrixA_12, matrixA_21, matrixA_22,
               matrixB_11, matrixB_12, matrixB_21, matrixB_22,
               ReLU, op_valid, frame_err, frame_count
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Double-buffered 2x2 int8 operand loader: frame presented one edge after its 8th byte, held >= HOLD_CYCLES and until ack.
// Backpressure: s_ready drops only while the shadow buffer holds a complete frame waiting for the presentation slot.
module matrix_operand_loader #(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_operand_loader_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0][7:0]  shadow_q, shadow_d;
    logic             sh_relu_q, sh_relu_d;
    logic             full_q, full_d;
    logic [7:0][7:0]  out_q, out_d;
    logic             relu_q, relu_d;
    logic [15:0]      hold_q, hold_d;
    logic             ack_seen_q, ack_seen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, release_slot, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shadow_q   <= '0;
            sh_relu_q  <= 1'b0;
            full_q     <= 1'b0;
            out_q      <= '0;
            relu_q     <= 1'b0;
            hold_q     <= '0;
            ack_seen_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            sh_relu_q  <= sh_relu_d;
            full_q     <= full_d;
            out_q      <= out_d;
            relu_q     <= relu_d;
            hold_q     <= hold_d;
            ack_seen_q <= ack_seen_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        sh_relu_d  = sh_relu_q;
        full_d     = full_q;
        out_d      = out_q;
        relu_d     = relu_q;
        hold_d     = hold_q;
        ack_seen_d = ack_seen_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;

        accept       = bus.s_valid && !full_q;
        release_slot = (state_q == PRESENT) && (hold_q == 16'd0) && (ack_seen_q || bus.op_ack);
        load         = full_q && ((state_q == IDLE) || release_slot);

        // Malformed frames are consumed byte-for-byte so the host never stalls on an error.
        if (accept) begin
            shadow_d[idx_q] = bus.s_data;
            if (idx_q == 3'd0) sh_relu_d = bus.cfg_relu;
            err_d = bus.s_last != (idx_q == 3'd7);
            if (bus.s_last || idx_q == 3'd7) idx_d = 3'd0;
            else                             idx_d = idx_q + 3'd1;
            if (bus.s_last && idx_q == 3'd7) full_d = 1'b1;
        end

        if (state_q == PRESENT) begin
            if (hold_q != 16'd0) hold_d = hold_q - 16'd1;
            if (bus.op_ack)      ack_seen_d = 1'b1;
            if (release_slot && !full_q) state_d = IDLE;
        end

        if (load) begin
            state_d    = PRESENT;
            out_d      = shadow_q;
            relu_d     = sh_relu_q;
            full_d     = 1'b0;
            hold_d     = HOLD_INIT;
            ack_seen_d = 1'b0;
            cnt_d      = cnt_q + 1'b1;
        end
    end

    assign bus.s_ready     = !full_q;
    assign bus.matrixA_11  = out_q[0];
    assign bus.matrixA_12  = out_q[1];
    assign bus.matrixA_21  = out_q[2];
    assign bus.matrixA_22  = out_q[3];
    assign bus.matrixB_11  = out_q[4];
    assign bus.matrixB_12  = out_q[5];
    assign bus.matrixB_21  = out_q[6];
    assign bus.matrixB_22  = out_q[7];
    assign bus.ReLU        = relu_q;
    assign bus.op_valid    = (state_q == PRESENT);
    assign bus.frame_err   = err_q;
    assign bus.frame_count = cnt_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: table of single frames plus hand-written multi-cycle sequences.
module tb_matrix_operand_loader;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mon_low = 0;
    logic mon_en = 1'b0;

    matrix_operand_loader_if #(.CNT_W(16)) ifc ();

    matrix_operand_loader #(.HOLD_CYCLES(10), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && !ifc.op_valid) mon_low <= mon_low + 1;

    logic [63:0] outv;
    assign outv = {ifc.matrixA_11, ifc.matrixA_12, ifc.matrixA_21, ifc.matrixA_22,
                   ifc.matrixB_11, ifc.matrixB_12, ifc.matrixB_21, ifc.matrixB_22};

    typedef struct {
        logic [63:0] dat;
        logic        relu;
        int          last_pos;   // byte index carrying s_last; 8 means none
        logic        exp_err;
        logic        exp_present;
        logic [63:0] exp_out;
        logic        exp_relu;
        int          exp_count;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic relu);
        bit ok = 0;
        ifc.s_valid  = 1'b1;
        ifc.s_data   = d;
        ifc.s_last   = last;
        ifc.cfg_relu = relu;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ifc.s_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h never accepted, s_ready stuck at %0b", d, ifc.s_ready);
        end
    endtask

    task automatic send_frame(input logic [63:0] dat, input int nb, input int last_pos, input logic relu);
        for (int i = 0; i < nb; i++)
            send_byte(dat[63-8*i -: 8], i == last_pos, relu);
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifc.s_valid = 1'($urandom_range(0, 1));
            ifc.op_ack  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ifc.s_valid = 1'b0;
        ifc.s_last  = 1'b0;
        ifc.op_ack  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (ifc.op_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (ifc.op_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: op_valid still %0b after %0d cycles, required 0", name, ifc.op_valid, n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int t1;
        int bad;
        rst_n        = 1'b0;
        ifc.s_valid  = 1'b0;
        ifc.s_data   = '0;
        ifc.s_last   = 1'b0;
        ifc.cfg_relu = 1'b0;
        ifc.op_ack   = 1'b0;

        vt[0] = '{64'h01020304_01020304, 1'b1, 7, 1'b0, 1'b1, 64'h01020304_01020304, 1'b1, 1};
        vt[1] = '{64'h0A0B0C0D_00000000, 1'b0, 3, 1'b1, 1'b0, 64'h01020304_01020304, 1'b1, 1};
        vt[2] = '{{8'd51, 8'd52, 8'd53, 8'd54, 8'd61, 8'd62, 8'd63, 8'd64}, 1'b0, 7, 1'b0, 1'b1,
                  {8'd51, 8'd52, 8'd53, 8'd54, 8'd61, 8'd62, 8'd63, 8'd64}, 1'b0, 2};
        vt[3] = '{64'hAAAAAAAA_AAAAAAAA, 1'b1, 8, 1'b1, 1'b0,
                  {8'd51, 8'd52, 8'd53, 8'd54, 8'd61, 8'd62, 8'd63, 8'd64}, 1'b0, 2};
        vt[4] = '{64'h80FF7F00_FE017F81, 1'b1, 7, 1'b0, 1'b1, 64'h80FF7F00_FE017F81, 1'b1, 3};

        // Reset with random activity on the inputs
        do_reset();
        @(negedge clk);
        check("reset_out", outv, 64'h0);
        check("reset_relu", 64'(ifc.ReLU), 64'h0);
        check("reset_op_valid", 64'(ifc.op_valid), 64'h0);
        check("reset_frame_err", 64'(ifc.frame_err), 64'h0);
        check("reset_count", 64'(ifc.frame_count), 64'h0);
        check("reset_s_ready", 64'(ifc.s_ready), 64'h1);
        @(posedge clk); #1;

        // Table of single frames, ack held high
        ifc.op_ack = 1'b1;
        for (int r = 0; r < 5; r++) begin
            send_frame(vt[r].dat, (vt[r].last_pos < 8) ? vt[r].last_pos + 1 : 8, vt[r].last_pos, vt[r].relu);
            @(negedge clk);
            check($sformatf("v%0d_frame_err", r), 64'(ifc.frame_err), 64'(vt[r].exp_err));
            check($sformatf("v%0d_not_yet_valid", r), 64'(ifc.op_valid), 64'h0);
            @(negedge clk);
            check($sformatf("v%0d_op_valid", r), 64'(ifc.op_valid), 64'(vt[r].exp_present));
            check($sformatf("v%0d_out", r), outv, vt[r].exp_out);
            check($sformatf("v%0d_relu", r), 64'(ifc.ReLU), 64'(vt[r].exp_relu));
            check($sformatf("v%0d_count", r), 64'(ifc.frame_count), 64'(vt[r].exp_count));
            check($sformatf("v%0d_err_cleared", r), 64'(ifc.frame_err), 64'h0);
            if (vt[r].exp_present) begin
                n = 0;
                while (ifc.op_valid && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                check($sformatf("v%0d_hold_len", r), 64'(n), 64'd10);
            end
            @(posedge clk); #1;
        end

        // Back-to-back frames
        do_reset();
        ifc.op_ack = 1'b1;
        send_frame({8'd11, 8'd12, 8'd13, 8'd14, 8'd21, 8'd22, 8'd23, 8'd24}, 8, 7, 1'b0);
        t1 = cyc;
        send_byte(8'd31, 1'b0, 1'b1);
        mon_en = 1'b1;
        send_frame({8'd32, 8'd33, 8'd34, 8'd41, 8'd42, 8'd43, 8'd44, 8'd0}, 7, 6, 1'b1);
        @(negedge clk);
        check("b2b_s_ready_low", 64'(ifc.s_ready), 64'h0);
        check("b2b_first_still_out", outv, {8'd11, 8'd12, 8'd13, 8'd14, 8'd21, 8'd22, 8'd23, 8'd24});
        n = 0;
        while (ifc.matrixA_11 != 8'd31 && n < 50) begin
            n++;
            @(negedge clk);
        end
        mon_en = 1'b0;
        check("b2b_switch_cycle", 64'(cyc - t1), 64'd11);
        check("b2b_no_gap", 64'(mon_low), 64'h0);
        check("b2b_second_out", outv, {8'd31, 8'd32, 8'd33, 8'd34, 8'd41, 8'd42, 8'd43, 8'd44});
        check("b2b_relu", 64'(ifc.ReLU), 64'h1);
        check("b2b_count", 64'(ifc.frame_count), 64'd2);
        wait_idle("b2b_drain");

        // Ack withheld with the next frame waiting
        do_reset();
        ifc.op_ack = 1'b0;
        send_frame({8'd71, 8'd72, 8'd73, 8'd74, 8'd75, 8'd76, 8'd77, 8'd78}, 8, 7, 1'b0);
        send_frame({8'd81, 8'd82, 8'd83, 8'd84, 8'd85, 8'd86, 8'd87, 8'd88}, 8, 7, 1'b1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!ifc.op_valid || ifc.s_ready ||
                outv != {8'd71, 8'd72, 8'd73, 8'd74, 8'd75, 8'd76, 8'd77, 8'd78}) bad++;
        end
        check("nack_stable_cycles_bad", 64'(bad), 64'h0);
        check("nack_count", 64'(ifc.frame_count), 64'd1);
        @(posedge clk); #1;
        ifc.op_ack = 1'b1;
        @(posedge clk); #1;
        ifc.op_ack = 1'b0;
        @(negedge clk);
        check("nack_next_out", outv, {8'd81, 8'd82, 8'd83, 8'd84, 8'd85, 8'd86, 8'd87, 8'd88});
        check("nack_next_relu", 64'(ifc.ReLU), 64'h1);
        check("nack_next_valid", 64'(ifc.op_valid), 64'h1);
        check("nack_next_count", 64'(ifc.frame_count), 64'd2);
        check("nack_s_ready_back", 64'(ifc.s_ready), 64'h1);
        ifc.op_ack = 1'b1;
        wait_idle("nack_drain");

        // Reset mid-frame while a frame is presented
        ifc.op_ack = 1'b0;
        send_frame({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8, 7, 1'b1);
        send_frame({8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd0, 8'd0, 8'd0}, 5, 8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", outv, 64'h0);
        check("async_rst_valid", 64'(ifc.op_valid), 64'h0);
        check("async_rst_count", 64'(ifc.frame_count), 64'h0);
        check("async_rst_relu", 64'(ifc.ReLU), 64'h0);
        do_reset();
        ifc.op_ack = 1'b1;
        send_frame({8'd91, 8'd98, 8'd93, 8'd95, 8'd111, 8'd102, 8'd123, 8'd104}, 8, 7, 1'b0);
        @(negedge clk);
        check("post_rst_no_err", 64'(ifc.frame_err), 64'h0);
        @(negedge clk);
        check("post_rst_out", outv, {8'd91, 8'd98, 8'd93, 8'd95, 8'd111, 8'd102, 8'd123, 8'd104});
        check("post_rst_relu", 64'(ifc.ReLU), 64'h0);
        check("post_rst_count", 64'(ifc.frame_count), 64'd1);
        wait_idle("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
